// File: rtl/conv_window_mac.sv
// conv_window_mac: per-tap convolution multiply-accumulate.
//   Takes one (i, j, r, c) tuple per beat. i/j pick the output pixel and r/c
//   pick the kernel tap. The block issues image and kernel RAM reads, then
//   multiplies the returned unsigned pixel by the signed weight. It sums the
//   K*K taps of each window and emits one output pixel per window.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   idx_valid, i, j, r, c  index tuple in (stage 0)
//   rd_en, img_addr, ker_addr   RAM read request (stage 1)
//   pix_data, ker_data    RAM read data, valid the cycle after rd_en
//   out_valid, out_addr, out_data, done   window result (stage 3)
//   err                   sticky protocol / range error
module conv_window_mac #(
  parameter int IN_W   = 4,
  parameter int K      = 2,
  parameter int OUT_W  = 3,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idx_valid,
  input  logic [IDX_W-1:0]  i,
  input  logic [IDX_W-1:0]  j,
  input  logic [IDX_W-1:0]  r,
  input  logic [IDX_W-1:0]  c,
  output logic              rd_en,
  output logic [ADDR_W-1:0] img_addr,
  output logic [ADDR_W-1:0] ker_addr,
  input  logic [DATA_W-1:0] pix_data,
  input  logic [DATA_W-1:0] ker_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ACC_W-1:0]  out_data,
  output logic              done,
  output logic              err
);

  localparam logic [IDX_W-1:0] OUT_LIM = IDX_W'(OUT_W);
  localparam logic [IDX_W-1:0] O_LAST  = IDX_W'(OUT_W - 1);
  localparam logic [IDX_W-1:0] K_LIM   = IDX_W'(K);
  localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(K - 1);

  // Sideband that travels with each tap until the accumulate stage.
  typedef struct packed {
    logic              first;
    logic              last;
    logic              fin;
    logic [ADDR_W-1:0] oaddr;
  } side_t;

  // ---------------- stage 0: range check and window tracking ---------------
  logic              in_range, take;
  logic              first0, last0;
  side_t             side0;
  logic [ADDR_W-1:0] img_addr_d, ker_addr_d;
  logic              win_open_q, win_open_d;
  logic              err_q, err_d;

  always_comb begin
    in_range   = (i < OUT_LIM) && (j < OUT_LIM) && (r < K_LIM) && (c < K_LIM);
    take       = idx_valid && in_range;
    first0     = (r == '0) && (c == '0);
    last0      = (r == K_LAST) && (c == K_LAST);
    side0.first = first0;
    side0.last  = last0;
    side0.fin   = last0 && (i == O_LAST) && (j == O_LAST);
    side0.oaddr = ADDR_W'(i) * ADDR_W'(OUT_W) + ADDR_W'(j);
    img_addr_d = (ADDR_W'(i) + ADDR_W'(r)) * ADDR_W'(IN_W) + ADDR_W'(j) + ADDR_W'(c);
    ker_addr_d = ADDR_W'(r) * ADDR_W'(K) + ADDR_W'(c);

    // A last tap always closes the window. With K=1 this means a tap that is
    // both first and last leaves the window closed.
    win_open_d = win_open_q;
    if (take) begin
      if (last0)       win_open_d = 1'b0;
      else if (first0) win_open_d = 1'b1;
    end

    err_d = err_q;
    if (idx_valid && !in_range)                 err_d = 1'b1;
    if (take && first0 && win_open_q)           err_d = 1'b1;
    if (take && !first0 && !win_open_q)         err_d = 1'b1;
  end

  // ---------------- stage 1 / 2 registers ----------------------------------
  // vld_pipe_q[1] is the read strobe; vld_pipe_q[2] marks RAM data arriving.
  logic [2:1]        vld_pipe_q;
  logic [ADDR_W-1:0] img_addr_q, ker_addr_q;
  side_t             s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      img_addr_q <= '0;
      ker_addr_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      win_open_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], take};
      s2_q       <= s1_q;
      win_open_q <= win_open_d;
      err_q      <= err_d;
      if (take) begin
        img_addr_q <= img_addr_d;
        ker_addr_q <= ker_addr_d;
        s1_q       <= side0;
      end
    end
  end

  // ---------------- stage 2: multiply-accumulate ---------------------------
  // Both operands are widened to ACC_W before the multiply. The product then
  // wraps modulo 2^ACC_W, which matches the accumulator arithmetic.
  logic signed [ACC_W-1:0] pix_ext, ker_ext, prod, sum_d;
  logic signed [ACC_W-1:0] acc_q;

  always_comb begin
    pix_ext = $signed({{(ACC_W-DATA_W){1'b0}}, pix_data});
    ker_ext = $signed({{(ACC_W-DATA_W){ker_data[DATA_W-1]}}, ker_data});
    prod    = pix_ext * ker_ext;
    sum_d   = s2_q.first ? prod : acc_q + prod;
  end

  // ---------------- stage 3: result registers ------------------------------
  logic              out_valid_q, done_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [ACC_W-1:0]  out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= vld_pipe_q[2] && s2_q.last;
      done_q      <= vld_pipe_q[2] && s2_q.last && s2_q.fin;
      if (vld_pipe_q[2]) begin
        acc_q <= sum_d;
        if (s2_q.last) begin
          out_data_q <= sum_d;
          out_addr_q <= s2_q.oaddr;
        end
      end
    end
  end

  assign rd_en     = vld_pipe_q[1];
  assign img_addr  = img_addr_q;
  assign ker_addr  = ker_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac. It models both RAMs with 1-cycle read
// latency. Image RAM holds p[a]=a, and kernel weights are held in w[].
// Window (i,j) with base b=i*4+j and w=1..4 sums to 10*b+34.
module tb_conv_window_mac;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       idx_valid;
  logic [3:0] i, j, r, c;
  logic       rd_en;
  logic [7:0] img_addr, ker_addr;
  logic [7:0] pix_data, ker_data;
  logic       out_valid;
  logic [7:0] out_addr;
  logic [19:0] out_data;
  logic       done, err;

  conv_window_mac dut (
    .clk(clk), .rst_n(rst_n), .idx_valid(idx_valid),
    .i(i), .j(j), .r(r), .c(c),
    .rd_en(rd_en), .img_addr(img_addr), .ker_addr(ker_addr),
    .pix_data(pix_data), .ker_data(ker_data),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] w [4];
  initial begin pix_data = 8'd0; ker_data = 8'd0; end
  always @(posedge clk) if (rd_en) begin
    pix_data <= img_addr;
    ker_data <= w[ker_addr[1:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int     oq_a[$], oq_c[$], ra[$], ka[$];
  longint oq_d[$];
  bit     oq_dn[$];
  int     n_done = 0;
  always @(negedge clk) begin
    if (out_valid) begin
      oq_a.push_back(int'(out_addr));
      oq_d.push_back(longint'($signed(out_data)));
      oq_dn.push_back(done);
      oq_c.push_back(cyc);
    end
    if (done) n_done++;
    if (rd_en) begin
      ra.push_back(int'(img_addr));
      ka.push_back(int'(ker_addr));
    end
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv(input bit v, input int ii, input int jj, input int rr, input int cc);
    @(posedge clk); #1;
    idx_valid = v; i = 4'(ii); j = 4'(jj); r = 4'(rr); c = 4'(cc);
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 0, 0, 0, 0);
  endtask

  int tlast;
  task automatic win(input int ii, input int jj, input int gap);
    for (int rr = 0; rr < 2; rr++)
      for (int cc = 0; cc < 2; cc++) begin
        drv(1'b1, ii, jj, rr, cc);
        tlast = cyc;
        if (gap > 0) idle(gap);
      end
  endtask

  task automatic clr();
    oq_a.delete(); oq_d.delete(); oq_dn.delete(); oq_c.delete();
    ra.delete(); ka.delete(); n_done = 0;
  endtask

  task automatic do_reset();
    idx_valid = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; idx_valid = 1'b0; i = '0; j = '0; r = '0; c = '0;
    w[0] = 8'd1; w[1] = 8'd2; w[2] = 8'd3; w[3] = 8'd4;
    #2 rst_n = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst rd_en", rd_en, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Window (0,0), back-to-back taps.
    clr(); win(0, 0, 0); idle(6);
    chk("w00 reads", ra.size(), 4);
    if (ra.size() == 4) begin
      chk("w00 img0", ra[0], 0); chk("w00 img1", ra[1], 1);
      chk("w00 img2", ra[2], 4); chk("w00 img3", ra[3], 5);
      chk("w00 ker0", ka[0], 0); chk("w00 ker1", ka[1], 1);
      chk("w00 ker2", ka[2], 2); chk("w00 ker3", ka[3], 3);
    end
    chk("w00 outs", oq_d.size(), 1);
    if (oq_d.size() == 1) begin
      chk("w00 data", oq_d[0], 34);
      chk("w00 addr", oq_a[0], 0);
      chk("w00 latency", oq_c[0] - tlast, 3);
    end

    // Full sweep in generator order.
    clr();
    for (int ii = 0; ii < 3; ii++)
      for (int jj = 0; jj < 3; jj++) win(ii, jj, 0);
    idle(6);
    chk("sweep outs", oq_d.size(), 9);
    if (oq_d.size() == 9)
      for (int k = 0; k < 9; k++) begin
        chk($sformatf("sweep addr%0d", k), oq_a[k], k);
        chk($sformatf("sweep data%0d", k), oq_d[k], 10 * (4 * (k / 3) + k % 3) + 34);
        chk($sformatf("sweep done%0d", k), oq_dn[k], (k == 8) ? 1 : 0);
      end
    chk("sweep done count", n_done, 1);
    chk("sweep err", err, 0);

    // Two idle cycles between every tap.
    clr(); win(0, 0, 2); idle(6);
    chk("gap reads", ra.size(), 4);
    chk("gap outs", oq_d.size(), 1);
    if (oq_d.size() == 1) chk("gap data", oq_d[0], 34);

    // Negative weights on the last window.
    w[0] = 8'hFF; w[1] = 8'hFE; w[2] = 8'hFD; w[3] = 8'hFC;
    clr(); win(2, 2, 0); idle(6);
    chk("neg outs", oq_d.size(), 1);
    if (oq_d.size() == 1) begin
      chk("neg data", oq_d[0], -134);
      chk("neg addr", oq_a[0], 8);
      chk("neg done", oq_dn[0], 1);
    end
    w[0] = 8'd1; w[1] = 8'd2; w[2] = 8'd3; w[3] = 8'd4;

    // Reset mid-window: outputs clear at once and the partial sum is dropped.
    clr();
    drv(1'b1, 0, 0, 0, 0);
    drv(1'b1, 0, 0, 0, 1);
    @(posedge clk); #2;
    chk("pre-reset rd_en", rd_en, 1);
    rst_n = 1'b0; idx_valid = 1'b0;
    #1;
    chk("mid rst rd_en", rd_en, 0);
    chk("mid rst img_addr", img_addr, 0);
    chk("mid rst ker_addr", ker_addr, 0);
    chk("mid rst out_data", out_data, 0);
    chk("mid rst out_addr", out_addr, 0);
    @(negedge clk) rst_n = 1'b1;
    clr(); win(0, 0, 0); idle(6);
    chk("post rst outs", oq_d.size(), 1);
    if (oq_d.size() == 1) chk("post rst data", oq_d[0], 34);
    chk("post rst err", err, 0);

    // Out-of-range row is dropped and flags err.
    clr(); drv(1'b1, 3, 0, 0, 0); idle(5);
    chk("oor reads", ra.size(), 0);
    chk("oor outs", oq_d.size(), 0);
    chk("oor err", err, 1);

    // Abandoned window: a new first tap restarts the sum.
    do_reset();
    chk("abandon err pre", err, 0);
    clr();
    drv(1'b1, 0, 0, 0, 0);
    drv(1'b1, 0, 0, 0, 1);
    win(1, 1, 0); idle(6);
    chk("abandon outs", oq_d.size(), 1);
    if (oq_d.size() == 1) begin
      chk("abandon data", oq_d[0], 84);
      chk("abandon addr", oq_a[0], 4);
    end
    chk("abandon err", err, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/conv_window_mac.md
Name: conv_window_mac

Overview:
- Downstream consumer of the nested loop-index generator.
- Takes one (i, j, r, c) index tuple per beat, where i/j select the output pixel and r/c select the kernel tap.
- Issues image-RAM and kernel-RAM read addresses, multiplies the returned pixel by the returned weight, and accumulates over the K*K taps of each window.
- Emits one output pixel per window, with its output-buffer address, plus a done pulse after the final window.

Parameters:
- IN_W, 4: input image width/height in pixels.
- K, 2: kernel width/height.
- OUT_W, 3: output width/height; must equal IN_W-K+1.
- IDX_W, 4: width of each index input.
- DATA_W, 8: pixel and weight width.
- ADDR_W, 8: address width for image, kernel and output addresses.
- ACC_W, 20: accumulator/output width; must be >= 2*DATA_W+clog2(K*K)+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- idx_valid  in  1  index tuple valid this cycle.
- i  in  IDX_W  output row.
- j  in  IDX_W  output column.
- r  in  IDX_W  kernel row.
- c  in  IDX_W  kernel column.
- rd_en  out  1  RAM read strobe.
- img_addr  out  ADDR_W  image address = (i+r)*IN_W + (j+c).
- ker_addr  out  ADDR_W  kernel address = r*K + c.
- pix_data  in  DATA_W  unsigned pixel; valid the cycle after rd_en.
- ker_data  in  DATA_W  signed weight; valid the cycle after rd_en.
- out_valid  out  1  one-cycle pulse, output pixel ready.
- out_addr  out  ADDR_W  output address = i*OUT_W + j.
- out_data  out  ACC_W  signed window sum.
- done  out  1  one-cycle pulse coincident with out_valid of the window (OUT_W-1, OUT_W-1).
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset: the asynchronous assert of rst_n clears every register at once.
  - All outputs go to 0 and the accumulator goes to 0.
  - All pipeline valid bits clear and window_open clears.
  - Reset during a window discards the partial sum; no out_valid is produced for it.
- Stage 0, cycle t: idx_valid is sampled and the tuple is range-checked (i,j < OUT_W; r,c < K).
  - Out-of-range tuple: dropped, err set, no rd_en.
- Stage 1, cycle t+1: registered outputs become valid.
  - rd_en=1; img_addr and ker_addr as defined above.
  - Sideband piped alongside: first = (r==0 && c==0), last = (r==K-1 && c==K-1), out_addr, is_final = (last && i==OUT_W-1 && j==OUT_W-1).
- Stage 2, end of cycle t+2: pix_data and ker_data are sampled.
  - prod = zero-extended pix * sign-extended weight, signed.
  - acc <= first ? prod : acc + prod.
  - Arithmetic wraps modulo 2^ACC_W; no saturation.
- Stage 3, cycle t+3: if the beat was last, out_valid=1, out_data = final sum, out_addr from sideband, done=is_final.
- Latency: 3 cycles from the last tap's idx_valid to out_valid.
- Throughput: one tap per cycle.
- idx_valid may drop between taps or windows; the accumulator and window_open hold their values.
- window_open: set by a first tap, cleared by a last tap.
  - first tap while window_open=1: err set; acc restarts from this tap's product (the old partial sum is discarded).
  - Non-first tap while window_open=0: err set; the tap is accumulated onto the current acc.
  - K=1: a tap is both first and last; it is emitted directly with no error.
- Tap order within a window is free, provided the (0,0) tap comes first and the (K-1,K-1) tap comes last.
- err is cleared only by reset.
- out_valid, done and rd_en are pulses: high exactly one cycle per qualifying beat, otherwise 0.

Test Plan (defaults; image RAM p[a]=a for a=0..15, kernel w[0..3]=1,2,3,4, both RAMs with 1-cycle latency):
- Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately; after release, the next complete window produces the correct sum with no stale partial.
- Window (0,0): taps (r,c)=(0,0),(0,1),(1,0),(1,1) on consecutive cycles -> img_addr 0,1,4,5; ker_addr 0,1,2,3; out_valid 3 cycles after the last tap with out_data=34, out_addr=0.
- Full sweep: 36 beats in generator order, (i,j) outer and (r,c) inner.
  - out_valid 9 times with out_addr 0..8.
  - Window (1,1) gives 84 at addr 4; window (2,2) gives 134 at addr 8.
  - done high only with the addr-8 output; err stays 0.
- Gaps: idx_valid deasserted 2 cycles between each tap of window (0,0) -> out_data still 34, one out_valid, no duplicates.
- Signed weights: w = -1,-2,-3,-4 for window (2,2) -> out_data=-134 (two's complement in ACC_W).
- Errors:
  - i=3 presented -> dropped, err=1, no rd_en.
  - A new first tap after 2 taps of a window -> err=1, and the next window sum excludes the abandoned taps.
